// File: rtl/conv_window_gen_5x5.sv
// Streaming 5x5 sliding-window generator: raster pixel stream in, stride-1
// unpadded 5x5 window (IF1 = top-left .. IF25 = bottom-right) plus valid out.
module conv_window_gen_5x5 #(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned COL_W = $clog2(IMG_W),
    localparam int unsigned ROW_W = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_W-1:0]     in_pixel,
    output logic                  win_valid,
    output logic [25*DATA_W-1:0]  win_out,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  frame_done
);

    localparam int unsigned K     = 5;
    localparam int unsigned LINES = 4;

    logic [ROW_W-1:0]  r, r_cur, r_nxt;
    logic [COL_W-1:0]  c, c_cur, c_nxt;
    logic [DATA_W-1:0] lb      [LINES][IMG_W];
    logic [DATA_W-1:0] win     [K][K];
    logic [DATA_W-1:0] new_col [K];
    logic              win_hit;
    logic              last_px;

    // Position of the current pixel; start-of-frame forces it to (0,0)
    always_comb begin
        r_cur = in_sof ? '0 : r;
        c_cur = in_sof ? '0 : c;
        r_nxt = r_cur;
        c_nxt = c_cur + COL_W'(1);
        if (c_cur == COL_W'(IMG_W - 1)) begin
            c_nxt = '0;
            r_nxt = (r_cur == ROW_W'(IMG_H - 1)) ? '0 : r_cur + ROW_W'(1);
        end
        win_hit = (r_cur >= ROW_W'(4)) && (c_cur >= COL_W'(4));
        last_px = (r_cur == ROW_W'(IMG_H - 1)) && (c_cur == COL_W'(IMG_W - 1));
        new_col[0] = lb[3][c_cur];
        new_col[1] = lb[2][c_cur];
        new_col[2] = lb[1][c_cur];
        new_col[3] = lb[0][c_cur];
        new_col[4] = in_pixel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r <= '0;
            c <= '0;
        end else if (in_valid) begin
            r <= r_nxt;
            c <= c_nxt;
        end
    end

    // Line buffers carry no reset; the row counter gates any stale content
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb[3][c_cur] <= lb[2][c_cur];
            lb[2][c_cur] <= lb[1][c_cur];
            lb[1][c_cur] <= lb[0][c_cur];
            lb[0][c_cur] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][K-1] <= new_col[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            win_valid  <= in_valid && win_hit;
            frame_done <= in_valid && win_hit && last_px;
            if (in_valid && win_hit) begin
                out_row <= r_cur - ROW_W'(4);
                out_col <= c_cur - COL_W'(4);
            end
        end
    end

    // Row-major flattening of the window registers
    always_comb begin
        win_out = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                win_out[(i*K+j)*DATA_W +: DATA_W] = win[i][j];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen_5x5.sv
// Bench for conv_window_gen_5x5: random-duty ramp frames checked against a
// frame-image model that cuts each expected 5x5 window straight out of the image.
module tb_conv_window_gen_5x5;

    localparam int unsigned W    = 32;
    localparam int unsigned H    = 32;
    localparam int unsigned DW   = 8;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned OW   = W - 4;
    localparam int unsigned OH   = H - 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_sof;
    logic [DW-1:0]  in_pixel;
    logic           win_valid;
    logic [25*DW-1:0] win_out;
    logic [4:0]     out_row;
    logic [4:0]     out_col;
    logic           frame_done;

    conv_window_gen_5x5 #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .win_valid  (win_valid),
        .win_out    (win_out),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] img   [H][W];
    int         pos;
    int         win_cnt, done_cnt, done_row, done_col;
    logic [7:0] cap1  [OH][OW];
    logic [7:0] cap13 [OH][OW];
    logic [7:0] cap25 [OH][OW];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: update the image model, apply inputs, then compare outputs
    task automatic drive(input logic v, input logic sof, input logic [7:0] pix);
        logic         ev, ed;
        int           er, ec, pr, pc;
        logic [199:0] ew;
        ev = 1'b0; ed = 1'b0; er = 0; ec = 0; ew = '0;
        if (v) begin
            if (sof) pos = 0;
            pr = pos / W;
            pc = pos % W;
            img[pr][pc] = pix;
            if (pr >= 4 && pc >= 4) begin
                ev = 1'b1;
                er = pr - 4;
                ec = pc - 4;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        ew[(i*5+j)*8 +: 8] = img[er+i][ec+j];
            end
            ed  = (pos == NPIX - 1);
            pos = (pos + 1) % NPIX;
        end
        in_valid = v;
        in_sof   = sof;
        in_pixel = pix;
        @(posedge clk);
        #1;
        check("win_valid", 256'(win_valid), 256'(ev));
        check("frame_done", 256'(frame_done), 256'(ed));
        if (ev) begin
            check("out_row", 256'(out_row), 256'(er));
            check("out_col", 256'(out_col), 256'(ec));
            check("win_out", 256'(win_out), 256'(ew));
        end
        if (win_valid === 1'b1) begin
            win_cnt++;
            if (out_row < 5'(OH) && out_col < 5'(OW)) begin
                cap1 [out_row][out_col] = win_out[7:0];
                cap13[out_row][out_col] = win_out[12*8 +: 8];
                cap25[out_row][out_col] = win_out[24*8 +: 8];
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_row = int'(out_row);
            done_col = int'(out_col);
        end
    endtask

    // Ramp (or inverted ramp) pixels 0..n-1 of a frame, optional random idles
    task automatic send_pixels(input int n, input bit use_sof, input bit inv, input bit duty);
        logic [7:0] v;
        win_cnt = 0; done_cnt = 0; done_row = -1; done_col = -1;
        for (int k = 0; k < n; k++) begin
            if (duty) begin
                for (int g = 0; g < 8; g++) begin
                    if ($urandom_range(1, 0) == 0) break;
                    drive(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
                end
            end
            v = 8'(k & 255);
            drive(1'b1, use_sof && (k == 0), inv ? 8'(255 - int'(v)) : v);
        end
    endtask

    task automatic frame_checks();
        check("window_count", 256'(win_cnt), 256'(OW * OH));
        check("done_count", 256'(done_cnt), 256'(1));
        check("done_row", 256'(done_row), 256'(OH - 1));
        check("done_col", 256'(done_col), 256'(OW - 1));
    endtask

    task automatic ramp_first_checks();
        check("first_if1", 256'(cap1[0][0]), 256'(0));
        check("first_if13", 256'(cap13[0][0]), 256'(66));
        check("first_if25", 256'(cap25[0][0]), 256'(132));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_win_valid"}, 256'(win_valid), 256'(0));
        check({tag, "_frame_done"}, 256'(frame_done), 256'(0));
        check({tag, "_win_out"}, 256'(win_out), 256'(0));
        check({tag, "_out_row"}, 256'(out_row), 256'(0));
        check({tag, "_out_col"}, 256'(out_col), 256'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        pos      = 0;
        #12;
        check_cleared("reset");
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous ramp frame, including row-edge windows
        send_pixels(NPIX, 1'b1, 1'b0, 1'b0);
        frame_checks();
        ramp_first_checks();
        check("edge_if1_r0c27", 256'(cap1[0][27]), 256'(27));
        check("edge_if25_r0c27", 256'(cap25[0][27]), 256'(159));
        check("edge_if1_r1c0", 256'(cap1[1][0]), 256'(32));
        check("edge_if25_r1c0", 256'(cap25[1][0]), 256'(164));

        // Same ramp with random idle cycles
        send_pixels(NPIX, 1'b1, 1'b0, 1'b1);
        frame_checks();
        ramp_first_checks();

        // Resync: new frame starts where pixel (10,7) would have been
        send_pixels(10 * W + 7, 1'b1, 1'b0, 1'b0);
        check("abort_done_count", 256'(done_cnt), 256'(0));
        send_pixels(NPIX, 1'b1, 1'b0, 1'b0);
        frame_checks();
        ramp_first_checks();

        // Asynchronous reset mid-frame; next frame sent without in_sof
        send_pixels(15 * W + 15, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_cleared("midreset");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        pos = 0;
        send_pixels(NPIX, 1'b0, 1'b0, 1'b0);
        frame_checks();
        ramp_first_checks();

        // Back-to-back ramp then inverted ramp
        send_pixels(NPIX, 1'b1, 1'b0, 1'b0);
        frame_checks();
        send_pixels(NPIX, 1'b1, 1'b1, 1'b0);
        frame_checks();
        check("inv_if1", 256'(cap1[0][0]), 256'(255));
        check("inv_if25", 256'(cap25[0][0]), 256'(123));

        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h5a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_gen_5x5.md
Name: conv_window_gen_5x5

Overview:
- Streaming 5x5 sliding-window generator for the LeNet front end.
- Accepts a raster-order 8-bit pixel stream, one pixel per accepted cycle.
- Buffers the last 4 image rows in line buffers.
- Presents a stride-1, unpadded 5x5 window plus a valid strobe, feeding the conv_pe_5x5 IF1..IF25 inputs and its valid_in directly.

Parameters:
- IMG_W, 32, image width in pixels (min 5)
- IMG_H, 32, image height in rows (min 5)
- DATA_W, 8, pixel width in bits

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  pixel qualifier; pixel accepted on every clk edge where high
- in_sof  in  1  start of frame; sampled only with in_valid; marks the pixel as (0,0)
- in_pixel  in  DATA_W  unsigned pixel
- win_valid  out  1  window valid; drives conv_pe_5x5 valid_in
- win_out  out  25*DATA_W  window, row-major
  - [DATA_W-1:0] = IF1 = top-left (r-4,c-4)
  - [25*DATA_W-1:24*DATA_W] = IF25 = bottom-right (r,c)
- out_row  out  $clog2(IMG_H)  output-map row of current window (r-4)
- out_col  out  $clog2(IMG_W)  output-map column of current window (c-4)
- frame_done  out  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (async, reset_n low):
  - win_valid, frame_done, out_row, out_col, win_out all 0.
  - Row/col counters r, c = 0.
  - Line-buffer contents are not reset. No window is issued until 4 fresh rows have been written.
- Accepted pixel (in_valid=1) at counter position (r,c):
  - Window shifts left one column; the old column 0 is discarded.
  - New rightmost column, top to bottom = lb3[c], lb2[c], lb1[c], lb0[c], in_pixel. lb3 holds the oldest row.
  - Line buffers shift at address c: lb3[c]<=lb2[c], lb2[c]<=lb1[c], lb1[c]<=lb0[c], lb0[c]<=in_pixel.
  - c increments. At c=IMG_W-1, c wraps to 0 and r increments. At r=IMG_H-1 with c=IMG_W-1, both wrap to 0.
- Output timing:
  - win_valid is registered and goes high the cycle after accepting a pixel with r>=4 and c>=4. Latency is 1 cycle.
  - win_out, out_row=r-4 and out_col=c-4 update in that same cycle.
  - frame_done=1 with the window for pixel (IMG_H-1, IMG_W-1).
- Windows per frame: (IMG_W-4)*(IMG_H-4), which is 784 for 32x32.
- in_valid=0: counters, line buffers and window hold. win_valid=0 and frame_done=0 next cycle. win_out holds its last value.
- Row boundary: no reset of the window shift register is needed. Columns 0..3 of a row refill the window before c=4, so no window ever straddles two rows.
- in_sof=1 with in_valid=1: the pixel is treated as (0,0) regardless of counters, then counting continues from (0,1).
  - Mid-frame in_sof aborts the current frame with no frame_done.
  - The next window is issued at pixel (4,4) of the new frame.
- in_sof=1 with in_valid=0: ignored.
- Reset asserted mid-frame: outputs are cleared immediately (async). The next frame must restart at pixel (0,0). Stale line-buffer data is never exposed.
- No backpressure: the downstream PE accepts every cycle.
- Arithmetic: counters only, no saturation paths. Line buffers are 4 x IMG_W x DATA_W, inferred as RAM or registers.

Test Plan:
1. Ramp frame, 32x32, pixel=(r*32+c)&0xFF, in_valid continuous, in_sof on the first pixel.
   - First win_valid one cycle after pixel (4,4) is accepted.
   - IF1=0, IF13=66, IF25=132, out_row=0, out_col=0.
   - Exactly 784 win_valid cycles; frame_done coincides with out_row=27, out_col=27.
2. Same ramp with in_valid pseudo-random at 50% duty.
   - Identical window sequence, same order and contents as scenario 1.
   - win_valid never high in the cycle after an idle (in_valid=0) cycle.
3. Row-edge check.
   - Window for out_row=0, out_col=27: IF1=27, IF25=(4*32+31)&0xFF=159.
   - Next window is out_row=1, out_col=0: IF1=32, IF25=164.
4. Mid-frame resync: in_sof asserted at pixel (10,7) of frame 1, then a full new ramp frame.
   - No frame_done for frame 1.
   - 784 windows follow, matching scenario 1.
5. reset_n pulsed low for 3 cycles at pixel (15,15), then a new full frame.
   - win_valid falls asynchronously.
   - First post-reset window appears only after pixel (4,4); contents match scenario 1.
6. Two back-to-back frames with no gap: frame 1 ramp, frame 2 inverted ramp (255 - value).
   - frame_done at the end of frame 1.
   - Next window is frame 2 (0,0) with IF1=255, IF25=123.
